// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative radix-2 multiply/divide unit that owns the HI/LO register pair.
//   It handles MULT, MULTU, DIV and DIVU and takes MTHI/MTLO writes. Each
//   operation takes 32 iteration cycles plus one sign-fix cycle. The pipeline
//   stalls while busy is high.
//
// Ports
//   clk    in   rising-edge clock
//   clr_n  in   asynchronous active-low reset
//   start  in   launch an operation (sampled only when idle)
//   op     in   2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU
//   a      in   dividend / multiplicand (regfile port a)
//   b      in   divisor / multiplier (regfile port b)
//   mthi   in   write wdata to HI (idle, no start)
//   mtlo   in   write wdata to LO (idle, no start)
//   wdata  in   data for MTHI/MTLO
//   busy   out  operation in progress
//   done   out  one-cycle pulse after HI/LO were updated by an operation
//   dz     out  divide-by-zero flag, held until the next accepted start
//   hi     out  HI register
//   lo     out  LO register
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ACC_W = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand magnitude, or divisor magnitude
  logic [WIDTH-1:0]   a_raw_q;  // raw dividend, returned in HI on divide by zero
  logic               is_div_q;
  logic               neg_q_q;  // negate product / quotient
  logic               neg_r_q;  // negate remainder
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_q;

  // The op encoding: bit 1 selects divide, bit 0 selects unsigned.
  logic is_div, is_signed;
  assign is_div    = op[1];
  assign is_signed = ~op[0];

  logic accept;
  assign accept = (state_q == IDLE) && start;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: all state is updated with non-blocking assignments in always_ff.
  // Blocking assignments would let one register's new value leak into another
  // register's update in the same cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case. Without it, any path that
  // does not assign state_d would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Operand setup at launch
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [ACC_W-1:0] acc_init;
  logic [WIDTH-1:0] opnd_init;

  always_comb begin
    mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
    acc_init  = '0;
    opnd_init = '0;
    if (is_div) begin
      // Remainder/quotient register starts with the dividend in the low half.
      acc_init[WIDTH-1:0] = mag_a;
      opnd_init           = mag_b;
    end else begin
      // Multiplier sits in the low half and is shifted out LSB first.
      acc_init[WIDTH-1:0] = mag_b;
      opnd_init           = mag_a;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [ACC_W-1:0] mul_next;
  logic [ACC_W-1:0] div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [ACC_W-1:0] div_next;

  always_comb begin
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the accumulator right by one.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
    mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: shift left, try to subtract the divisor from the
    // partial remainder, and keep the difference only if it did not go
    // negative. The quotient bit enters at the LSB.
    div_shift = {acc_q[2*WIDTH-1:0], 1'b0};
    div_diff  = {1'b0, div_shift[2*WIDTH:WIDTH]} - {2'b00, opnd_q};
    if (!div_diff[WIDTH+1])
      div_next = {div_diff[WIDTH:0], div_shift[WIDTH-1:1], 1'b1};
    else
      div_next = div_shift;
  end

  // The top accumulator bit only carries the transient borrow headroom.
  // The next iteration does not read it.
  logic unused_acc_msb;
  assign unused_acc_msb = acc_q[ACC_W-1];

  // ---------------------------------------------------------------------------
  // Result sign correction (evaluated while in FIX)
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    prod     = acc_q[2*WIDTH-1:0];
    prod_fix = neg_q_q ? -prod : prod;
    quot_fix = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (dz_q) begin
      // On divide by zero, LO is all ones and HI holds the untouched dividend.
      res_hi = a_raw_q;
      res_lo = '1;
    end else begin
      res_hi = rem_fix;
      res_lo = quot_fix;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: every register here is a flop and has an explicit reset value, so
  // a reset mid-operation leaves a clean, known state. There are no memory
  // arrays that would need to stay out of reset.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      acc_q    <= acc_init;
      opnd_q   <= opnd_init;
      a_raw_q  <= a;
      is_div_q <= is_div;
      neg_q_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r_q  <= is_signed & is_div & a[WIDTH-1];
      dz_q     <= is_div & (b == '0);
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + CNT_W'(1);
      acc_q <= is_div_q ? div_next : mul_next;
    end
  end

  // HI/LO load the result on leaving FIX. Otherwise they take MTHI/MTLO
  // writes, but only when idle and no start competes in the same cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == FIX);
      if (state_q == FIX) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state_q == IDLE && !start) begin
        if (mthi) hi_q <= wdata;
        if (mtlo) lo_q <= wdata;
      end
    end
  end

  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit. Expected HI/LO/dz come from a plain
//   arithmetic reference model (64-bit products, language division/modulo).
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arithmetic on the operation's meaning.
  task automatic ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] e_hi, output logic [31:0] e_lo,
                           output logic e_dz);
    longint      sx, sy, q, r;
    logic [63:0] p, uq, ur;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    e_dz = 1'b0;
    case (o)
      2'b00: begin
        p = 64'(sx * sy);
        e_hi = p[63:32]; e_lo = p[31:0];
      end
      2'b01: begin
        p = {32'h0, x} * {32'h0, y};
        e_hi = p[63:32]; e_lo = p[31:0];
      end
      default: begin
        if (y == 32'h0) begin
          e_dz = 1'b1; e_hi = x; e_lo = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          q = sx / sy; r = sx % sy;
          p = 64'(q); e_lo = p[31:0];
          p = 64'(r); e_hi = p[31:0];
        end else begin
          uq = {32'h0, x} / {32'h0, y};
          ur = {32'h0, x} % {32'h0, y};
          e_lo = uq[31:0]; e_hi = ur[31:0];
        end
      end
    endcase
  endtask

  // Launch one operation from the current falling edge and follow it to done.
  // With inject set, it pulses a stray start at cycle 5 and mthi at cycle 10.
  // Both must be ignored.
  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y, input bit inject);
    logic [31:0] e_hi, e_lo;
    logic        e_dz;
    int          cnt;
    bit          overlap;
    ref_model(o, x, y, e_hi, e_lo, e_dz);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;  // operands must already be latched
    checks++;
    if (dz !== e_dz) begin
      errors++;
      $display("FAIL %s dz_after_start: got %b expected %b", name, dz, e_dz);
    end
    cnt = 0;
    overlap = 1'b0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (done !== 1'b0) overlap = 1'b1;
      start = inject && (cnt == 5);
      if (inject && cnt == 5) begin op = ~o; a = $urandom; b = $urandom; end
      mthi  = inject && (cnt == 10);
      wdata = $urandom;
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0;
    checks++;
    if (cnt != 33) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected 33", name, cnt);
    end
    checks++;
    if (overlap) begin
      errors++;
      $display("FAIL %s done_while_busy: got 1 expected 0", name);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_pulse: got %b expected 1", name, done);
    end
    checks++;
    if (hi !== e_hi || lo !== e_lo) begin
      errors++;
      $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, e_hi, e_lo);
    end
    checks++;
    if (dz !== e_dz) begin
      errors++;
      $display("FAIL %s dz_at_done: got %b expected %b", name, dz, e_dz);
    end
  endtask

  task automatic test_reset;
    clr_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, dz, hi, lo} !== 67'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h expected all 0",
               busy, done, dz, hi, lo);
    end
  endtask

  task automatic test_directed;
    run_op("mult_neg3x5",   2'b00, 32'hFFFF_FFFD, 32'd5,         1'b0);
    run_op("multu_max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div_m7_2",      2'b10, 32'hFFFF_FFF9, 32'd2,         1'b0);
    run_op("div_min_m1",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("div_7_m2",      2'b10, 32'd7,         32'hFFFF_FFFE, 1'b0);
  endtask

  task automatic test_div_zero;
    run_op("divu_7_0",      2'b11, 32'd7,         32'd0,         1'b0);
    run_op("divu_7_2",      2'b11, 32'd7,         32'd2,         1'b0);
    run_op("div_neg_0",     2'b10, 32'hFFFF_FF00, 32'd0,         1'b0);
  endtask

  task automatic test_busy_ignore;
    run_op("ignore_start_mthi", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
  endtask

  task automatic test_move;
    logic [31:0] old_hi;
    @(negedge clk);
    old_hi = hi;
    mtlo = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    mtlo = 1'b0;
    checks++;
    if (lo !== 32'h0000_1234 || hi !== old_hi || done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: got hi=%h lo=%h done=%b expected hi=%h lo=00001234 done=0",
               hi, lo, done, old_hi);
    end
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if (hi !== 32'hCAFE_F00D || lo !== 32'hCAFE_F00D || done !== 1'b0) begin
      errors++;
      $display("FAIL mthi_mtlo: got hi=%h lo=%h done=%b expected both cafef00d done=0",
               hi, lo, done);
    end
    // A start in the same cycle wins, and the move is dropped. The MULTU
    // result is checked at done. The dropped write must not leak into it.
    mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    run_op("start_beats_mthi", 2'b01, 32'd3, 32'd4, 1'b0);
    mthi = 1'b0;
  endtask

  task automatic test_reset_mid;
    op = 2'b00; a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    clr_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      errors++;
      $display("FAIL reset_mid_op: got busy=%b done=%b hi=%h lo=%h expected all 0",
               busy, done, hi, lo);
    end
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got busy=%b done=%b expected 0 0", busy, done);
    end
    run_op("after_reset", 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
  endtask

  // Random ops run back to back. Each starts in the done cycle of the last.
  task automatic test_back_to_back;
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) y = 32'h0;
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(16, 31);
      run_op("random", o, x, y, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_busy_ignore();
    test_move();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
